// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: sign-magnitude product to packed BCD,
// one magnitude bit per clock, with leading-zero blanking flags for the display.
module product_bcd_converter #(
  parameter int DATA_W     = 16,
  parameter int SIGNED_MAG = 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [DATA_W-1:0]                       product,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    sign,
  output logic [4*((DATA_W == 8) ? 3 : 5)-1:0]    bcd,
  output logic [((DATA_W == 8) ? 3 : 5)-1:0]      blank
);

  localparam int DIGITS = (DATA_W == 8) ? 3 : 5;
  localparam int N      = (SIGNED_MAG != 0) ? DATA_W - 1 : DATA_W;
  localparam int SW     = 4 * DIGITS;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [N-1:0]      r_shift;
  logic [SW-1:0]     r_scratch;
  logic [4:0]        r_cnt;
  logic              r_sign_lat;
  logic              w_accept;
  logic              w_last;
  logic [SW-1:0]     w_adj;
  logic [SW-1:0]     w_scratch_next;

  // Add 3 to every digit that is 5 or more so the following shift carries into the next digit.
  function automatic logic [SW-1:0] f_add3(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A digit is blanked when it and every digit above it is zero; units are never blanked.
  function automatic logic [DIGITS-1:0] f_blank(input logic [SW-1:0] v);
    logic [DIGITS-1:0] m;
    logic              hz;
    m  = '0;
    hz = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hz   = hz & (v[4*i +: 4] == 4'd0);
      m[i] = hz;
    end
    return m;
  endfunction

  assign w_accept       = (r_state == IDLE) && start;
  assign w_last         = (r_state == CONV) && (r_cnt == 5'd1);
  assign w_adj          = f_add3(r_scratch);
  assign w_scratch_next = {w_adj[SW-2:0], r_shift[N-1]};
  assign busy           = (r_state == CONV);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = CONV;
      CONV:    if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= 5'd0;
      done  <= 1'b0;
      sign  <= 1'b0;
      bcd   <= '0;
      blank <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_cnt <= 5'(N);
      end else if (r_state == CONV) begin
        r_cnt <= r_cnt - 5'd1;
        if (w_last) begin
          done  <= 1'b1;
          bcd   <= w_scratch_next;
          // Negative zero collapses to plain zero.
          sign  <= r_sign_lat && (w_scratch_next != '0);
          blank <= f_blank(w_scratch_next);
        end
      end
    end
  end

  // Datapath registers carry no reset; they are reloaded on every accepted start.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_shift    <= product[N-1:0];
      r_scratch  <= '0;
      r_sign_lat <= (SIGNED_MAG != 0) ? product[DATA_W-1] : 1'b0;
    end else if (r_state == CONV) begin
      r_shift   <= {r_shift[N-2:0], 1'b0};
      r_scratch <= w_scratch_next;
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: default, unsigned 16-bit and signed 8-bit builds.
module tb_product_bcd_converter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [15:0] prod_a = '0, prod_b = '0;
  logic [7:0]  prod_c = '0;

  logic        busy_a, done_a, sign_a;
  logic [19:0] bcd_a;
  logic [4:0]  blank_a;
  logic        busy_b, done_b, sign_b;
  logic [19:0] bcd_b;
  logic [4:0]  blank_b;
  logic        busy_c, done_c, sign_c;
  logic [11:0] bcd_c;
  logic [2:0]  blank_c;

  int errors = 0;
  int checks = 0;
  int sel    = 0;

  logic        m_busy, m_done, m_sign;
  logic [19:0] m_bcd;
  logic [4:0]  m_blank;

  always #5 clock = ~clock;

  product_bcd_converter u_dut_a (
    .clock(clock), .reset(reset), .start(start_a), .product(prod_a),
    .busy(busy_a), .done(done_a), .sign(sign_a), .bcd(bcd_a), .blank(blank_a));

  product_bcd_converter #(.DATA_W(16), .SIGNED_MAG(0)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b), .product(prod_b),
    .busy(busy_b), .done(done_b), .sign(sign_b), .bcd(bcd_b), .blank(blank_b));

  product_bcd_converter #(.DATA_W(8), .SIGNED_MAG(1)) u_dut_c (
    .clock(clock), .reset(reset), .start(start_c), .product(prod_c),
    .busy(busy_c), .done(done_c), .sign(sign_c), .bcd(bcd_c), .blank(blank_c));

  always_comb begin
    m_busy = busy_a; m_done = done_a; m_sign = sign_a; m_bcd = bcd_a; m_blank = blank_a;
    case (sel)
      1: begin m_busy = busy_b; m_done = done_b; m_sign = sign_b; m_bcd = bcd_b; m_blank = blank_b; end
      2: begin m_busy = busy_c; m_done = done_c; m_sign = sign_c;
               m_bcd = {8'h00, bcd_c}; m_blank = {2'b00, blank_c}; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v, input logic [15:0] p);
    case (s)
      1:       begin start_b = v; prod_b = p; end
      2:       begin start_c = v; prod_c = p[7:0]; end
      default: begin start_a = v; prod_a = p; end
    endcase
  endtask

  task automatic run(input string tag, input int s, input logic [15:0] p,
                     input logic [19:0] eb, input logic es, input logic [4:0] ebl, input int el);
    int  lat;
    bit  got;
    sel = s;
    @(negedge clock);
    set_start(s, 1'b1, p);
    @(posedge clock); #1;
    set_start(s, 1'b0, 16'h0000);
    check({tag, ".busy"}, 32'(m_busy), 32'd1);
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (m_done) got = 1;
    end
    check({tag, ".lat"}, lat, el);
    check({tag, ".bcd"}, 32'(m_bcd), 32'(eb));
    check({tag, ".sign"}, 32'(m_sign), 32'(es));
    check({tag, ".blank"}, 32'(m_blank), 32'(ebl));
    @(posedge clock); #1;
    check({tag, ".done_pulse"}, 32'(m_done), 32'd0);
    check({tag, ".busy_end"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    int lat, t0, t1, ndone;
    bit got;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst.busy", 32'(busy_a), 32'd0);
    check("rst.done", 32'(done_a), 32'd0);
    check("rst.sign", 32'(sign_a), 32'd0);
    check("rst.bcd", 32'(bcd_a), 32'd0);
    check("rst.blank", 32'(blank_a), 32'b11110);
    check("rst.blank_c", 32'(blank_c), 32'b110);

    run("zero",   0, 16'h0000, 20'h00000, 1'b0, 5'b11110, 15);
    run("max",    0, 16'h7FFF, 20'h32767, 1'b0, 5'b00000, 15);
    run("neg35",  0, 16'h8023, 20'h00035, 1'b1, 5'b11100, 15);
    run("negz",   0, 16'h8000, 20'h00000, 1'b0, 5'b11110, 15);
    run("u16max", 1, 16'hFFFF, 20'h65535, 1'b0, 5'b00000, 16);
    run("s8neg5", 2, 16'h0085, 20'h00005, 1'b1, 5'b00110, 7);

    // A second start during a conversion must be ignored.
    sel = 0;
    @(negedge clock); start_a = 1'b1; prod_a = 16'h1234;
    @(posedge clock); #1; start_a = 1'b0; prod_a = 16'h0000;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 4) begin start_a = 1'b1; prod_a = 16'h0001; end
      if (lat == 5) begin start_a = 1'b0; prod_a = 16'h0000; end
      if (done_a) got = 1;
    end
    check("ign.lat", lat, 15);
    check("ign.bcd", 32'(bcd_a), 32'h04660);
    check("ign.blank", 32'(blank_a), 32'b10000);
    repeat (2) @(posedge clock); #1;
    check("ign.idle", 32'(busy_a), 32'd0);

    // Start held high yields one conversion every N+1 cycles.
    @(negedge clock); start_a = 1'b1; prod_a = 16'h0063;
    t0 = 0; t1 = 0; ndone = 0; lat = 0;
    while (ndone < 2 && lat < 80) begin
      @(posedge clock); #1;
      lat++;
      if (done_a) begin
        if (ndone == 0) t0 = lat; else t1 = lat;
        ndone++;
      end
    end
    check("held.count", ndone, 2);
    check("held.period", t1 - t0, 16);
    check("held.bcd", 32'(bcd_a), 32'h00099);
    start_a = 1'b0;
    lat = 0;
    while (busy_a && lat < 40) begin @(posedge clock); #1; lat++; end
    check("held.drain", 32'(busy_a), 32'd0);
    repeat (2) @(posedge clock); #1;

    // Reset in the middle of a conversion.
    @(negedge clock); start_a = 1'b1; prod_a = 16'h1234;
    @(posedge clock); #1; start_a = 1'b0;
    repeat (7) @(posedge clock); #1;
    check("mid.busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    check("mid.busy0", 32'(busy_a), 32'd0);
    check("mid.done0", 32'(done_a), 32'd0);
    check("mid.bcd0", 32'(bcd_a), 32'd0);
    check("mid.blank0", 32'(blank_a), 32'b11110);
    ndone = 0;
    repeat (20) begin @(posedge clock); #1; if (done_a) ndone++; end
    check("mid.nodone", ndone, 0);
    run("after", 0, 16'h0063, 20'h00099, 1'b0, 5'b11100, 15);

    // Reset and start together: reset wins.
    @(negedge clock); reset = 1'b1; start_a = 1'b1; prod_a = 16'h0005;
    @(posedge clock); #1; reset = 1'b0; start_a = 1'b0;
    check("rs.busy", 32'(busy_a), 32'd0);
    @(posedge clock); #1;
    check("rs.busy2", 32'(busy_a), 32'd0);
    check("rs.bcd", 32'(bcd_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
